// File: rtl/dma_pkg.sv
// Shared types and constants for the block-copy DMA engine.
// Provides the FSM state encoding, the page-register offset, the last valid
// data offset within a page and the {page, offset} physical-address struct.
package dma_pkg;

    localparam logic [7:0] ADR_STRONY = 8'd255; // page register lives at this offset
    localparam logic [7:0] OFFSET_MAX = 8'd254; // last offset usable for data

    typedef enum logic [3:0] {
        IDLE,
        REQ,
        SAVE,
        SET_SRC,
        READ,
        SET_DST,
        WRITE,
        RESTORE,
        DONE
    } state_t;

    typedef struct packed {
        logic [3:0] page;
        logic [7:0] offset;
    } phys_adr_t;

endpackage

// File: rtl/dma_adr_inc.sv
// Physical-address incrementer for the paged memory.
// Ports:
//   adr_i - current {page, offset}
//   adr_o - next data address; offset 254 wraps to offset 0 of the next page
//           (page wraps mod 16), so offset 255 (page register) is never produced.
module dma_adr_inc
    import dma_pkg::*;
(
    input  phys_adr_t adr_i,
    output phys_adr_t adr_o
);

    always_comb begin
        adr_o = adr_i;
        if (adr_i.offset == OFFSET_MAX) begin
            adr_o.offset = 8'd0;
            adr_o.page   = adr_i.page + 4'd1;
        end else begin
            adr_o.offset = adr_i.offset + 8'd1;
        end
    end

endmodule

// File: rtl/dma_kopiuj_strony.sv
// Block-copy DMA engine for the paged data memory.
// Copies len bytes from src_adr to dst_adr (12-bit {page, offset} addresses),
// reaching the physical space by rewriting the page register at offset 255
// before every byte read and every byte write (4 cycles per byte).
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   start, src_adr,
//   dst_adr, len         - launch request and its parameters (sampled in IDLE)
//   busy, done, err      - status; done/err are one-cycle pulses
//   bus_req, bus_gnt     - memory bus request/grant; grant low stalls the FSM
//   mem_wr, mem_adres,
//   mem_dane, mem_out    - memory port (mem_out is combinational read data)
// Build option: define DMA_PRZYWROC_STRONE_EN to save the page register before
// the copy and restore it afterwards (SAVE/RESTORE states). Without it the page
// register is left at the last destination page.
module dma_kopiuj_strony
    import dma_pkg::*;
#(
    parameter int ADDR_WIDTH_MEM    = 8,
    parameter int DATA_WIDTH_MEM    = 8,
    parameter int DATA_WIDTH_STRONY = 4,
    parameter int LEN_WIDTH         = 12
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        start,
    input  logic [DATA_WIDTH_STRONY+ADDR_WIDTH_MEM-1:0] src_adr,
    input  logic [DATA_WIDTH_STRONY+ADDR_WIDTH_MEM-1:0] dst_adr,
    input  logic [LEN_WIDTH-1:0]                        len,
    output logic                                        busy,
    output logic                                        done,
    output logic                                        err,
    output logic                                        bus_req,
    input  logic                                        bus_gnt,
    output logic                                        mem_wr,
    output logic [ADDR_WIDTH_MEM-1:0]                   mem_adres,
    output logic [DATA_WIDTH_MEM-1:0]                   mem_dane,
    input  logic [DATA_WIDTH_MEM-1:0]                   mem_out
);

    localparam int PAD_W = DATA_WIDTH_MEM - DATA_WIDTH_STRONY;

    state_t                    state_q, state_d;
    phys_adr_t                 src_q, src_d, src_nxt;
    phys_adr_t                 dst_q, dst_d, dst_nxt;
    logic [LEN_WIDTH-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH_MEM-1:0] buf_q, buf_d;
    logic                      err_q, err_d;
`ifdef DMA_PRZYWROC_STRONE_EN
    logic [DATA_WIDTH_STRONY-1:0] orig_page_q, orig_page_d;
`endif

    dma_adr_inc u_inc_src (.adr_i(src_q), .adr_o(src_nxt));
    dma_adr_inc u_inc_dst (.adr_i(dst_q), .adr_o(dst_nxt));

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        err_d     = err_q;
`ifdef DMA_PRZYWROC_STRONE_EN
        orig_page_d = orig_page_q;
`endif
        busy      = (state_q != IDLE);
        done      = 1'b0;
        err       = 1'b0;
        bus_req   = 1'b0;
        mem_wr    = 1'b0;
        mem_adres = '0;
        mem_dane  = '0;

        // Every memory-side state keeps bus_req high and only advances (or
        // writes) while the grant is present, so a grant drop is a pure stall.
        case (state_q)
            IDLE: begin
                if (start) begin
                    src_d = phys_adr_t'(src_adr);
                    dst_d = phys_adr_t'(dst_adr);
                    cnt_d = len;
                    if (src_adr[ADDR_WIDTH_MEM-1:0] == ADR_STRONY ||
                        dst_adr[ADDR_WIDTH_MEM-1:0] == ADR_STRONY) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else if (len == '0) begin
                        err_d   = 1'b0;
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                bus_req = 1'b1;
                if (bus_gnt) begin
`ifdef DMA_PRZYWROC_STRONE_EN
                    state_d = SAVE;
`else
                    state_d = SET_SRC;
`endif
                end
            end
`ifdef DMA_PRZYWROC_STRONE_EN
            SAVE: begin
                bus_req   = 1'b1;
                mem_adres = ADR_STRONY;
                if (bus_gnt) begin
                    orig_page_d = mem_out[DATA_WIDTH_STRONY-1:0];
                    state_d     = SET_SRC;
                end
            end
`endif
            SET_SRC: begin
                bus_req   = 1'b1;
                mem_wr    = bus_gnt;
                mem_adres = ADR_STRONY;
                mem_dane  = {{PAD_W{1'b0}}, src_q.page};
                if (bus_gnt) state_d = READ;
            end
            READ: begin
                bus_req   = 1'b1;
                mem_adres = src_q.offset;
                if (bus_gnt) begin
                    buf_d   = mem_out;
                    state_d = SET_DST;
                end
            end
            SET_DST: begin
                bus_req   = 1'b1;
                mem_wr    = bus_gnt;
                mem_adres = ADR_STRONY;
                mem_dane  = {{PAD_W{1'b0}}, dst_q.page};
                if (bus_gnt) state_d = WRITE;
            end
            WRITE: begin
                bus_req   = 1'b1;
                mem_wr    = bus_gnt;
                mem_adres = dst_q.offset;
                mem_dane  = buf_q;
                if (bus_gnt) begin
                    src_d = src_nxt;
                    dst_d = dst_nxt;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == LEN_WIDTH'(1)) begin
`ifdef DMA_PRZYWROC_STRONE_EN
                        state_d = RESTORE;
`else
                        state_d = DONE;
`endif
                    end else begin
                        state_d = SET_SRC;
                    end
                end
            end
`ifdef DMA_PRZYWROC_STRONE_EN
            RESTORE: begin
                bus_req   = 1'b1;
                mem_wr    = bus_gnt;
                mem_adres = ADR_STRONY;
                mem_dane  = {{PAD_W{1'b0}}, orig_page_q};
                if (bus_gnt) state_d = DONE;
            end
`endif
            DONE: begin
                done    = 1'b1;
                err     = err_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
            err_q   <= 1'b0;
`ifdef DMA_PRZYWROC_STRONE_EN
            orig_page_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            err_q   <= err_d;
`ifdef DMA_PRZYWROC_STRONE_EN
            orig_page_q <= orig_page_d;
`endif
        end
    end

endmodule

// File: tb/tb_dma_kopiuj_strony.sv
// Self-checking bench for dma_kopiuj_strony: paged memory model, a transfer-level
// reference (cycle budget per byte, sequential byte copy on a snapshot) and
// directed plus randomized transfers.
module tb_dma_kopiuj_strony;

`ifdef DMA_PRZYWROC_STRONE_EN
    localparam bit RESTORE_EN = 1'b1;
    localparam int BASE = 4;
`else
    localparam bit RESTORE_EN = 1'b0;
    localparam int BASE = 2;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start = 1'b0;
    logic [11:0] src_adr = '0, dst_adr = '0, len = '0;
    logic        busy, done, err, bus_req, mem_wr;
    logic        bus_gnt = 1'b1;
    logic [7:0]  mem_adres, mem_dane, mem_out;

    dma_kopiuj_strony dut (
        .clk(clk), .rst(rst), .start(start), .src_adr(src_adr), .dst_adr(dst_adr),
        .len(len), .busy(busy), .done(done), .err(err), .bus_req(bus_req),
        .bus_gnt(bus_gnt), .mem_wr(mem_wr), .mem_adres(mem_adres),
        .mem_dane(mem_dane), .mem_out(mem_out)
    );

    // ---------------- paged memory ----------------
    logic [7:0]  mem [4096];
    logic [3:0]  page_reg;
    logic        bd_we = 1'b0, bd_page_we = 1'b0;
    logic [11:0] bd_addr = '0;
    logic [7:0]  bd_data = '0;

    assign mem_out = (mem_adres == 8'hFF) ? {4'h0, page_reg} : mem[{page_reg, mem_adres}];

    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        if (rst) page_reg <= 4'h0;
        else if (bd_page_we) page_reg <= bd_data[3:0];
        else if (mem_wr) begin
            if (mem_adres == 8'hFF) page_reg <= mem_dane[3:0];
            else mem[{page_reg, mem_adres}] <= mem_dane;
        end
    end

    // ---------------- scoring ----------------
    int vecs = 0;
    int errs = 0;

    task automatic chk(input string nm, input int got, input int exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [11:0] inc(input logic [11:0] a);
        if (a[7:0] == 8'hFE) return {a[11:8] + 4'd1, 8'h00};
        return a + 12'd1;
    endfunction

    function automatic bit is_rej(input logic [11:0] s, input logic [11:0] d);
        return (s[7:0] == 8'hFF) || (d[7:0] == 8'hFF);
    endfunction

    // ---------------- transfer-level reference ----------------
    // work = grant-high cycles still owed before the DONE cycle.
    int          cyc = 0;
    logic        act = 1'b0;
    int          work = 0;
    logic        rej = 1'b0;
    logic [11:0] m_src = '0, m_dst = '0;
    int          m_len = 0;
    logic [3:0]  m_page0 = '0;
    logic [7:0]  snap [4096];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) act <= 1'b0;
        else if (!act) begin
            if (start) begin
                act     <= 1'b1;
                rej     <= is_rej(src_adr, dst_adr);
                m_src   <= src_adr;
                m_dst   <= dst_adr;
                m_len   <= int'(len);
                snap    <= mem;
                m_page0 <= page_reg;
                work    <= (is_rej(src_adr, dst_adr) || len == 0) ? 0 : BASE + 4 * int'(len) - 1;
            end
        end else if (work == 0) act <= 1'b0;
        else if (bus_gnt) work <= work - 1;
    end

    task automatic check_mem();
        logic [7:0]  e [4096];
        logic [11:0] s, d;
        logic [3:0]  lastp;
        e = snap; s = m_src; d = m_dst; lastp = m_page0;
        if (!rej) for (int i = 0; i < m_len; i++) begin
            e[d] = e[s]; lastp = d[11:8]; s = inc(s); d = inc(d);
        end
        d = m_dst;
        if (!rej) for (int i = 0; i < m_len; i++) begin
            chk("mem_byte", int'(mem[d]), int'(e[d])); d = inc(d);
        end
        chk("page_reg", int'(page_reg), int'(RESTORE_EN ? m_page0 : lastp));
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            logic e_done, e_req;
            e_done = act && (work == 0);
            e_req  = act && !e_done;
            chk("busy", int'(busy), int'(act));
            chk("done", int'(done), int'(e_done));
            chk("err", int'(err), int'(e_done && rej));
            chk("bus_req", int'(bus_req), int'(e_req));
            if (!bus_gnt || !e_req) chk("mem_wr_idle", int'(mem_wr), 0);
            if (e_done) check_mem();
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic bd_byte(input logic [11:0] a, input logic [7:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d; tick(); bd_we = 1'b0;
    endtask

    task automatic bd_page(input logic [3:0] p);
        bd_page_we = 1'b1; bd_data = {4'h0, p}; tick(); bd_page_we = 1'b0;
    endtask

    task automatic launch(input logic [11:0] s, input logic [11:0] d, input logic [11:0] l,
                          output int k);
        src_adr = s; dst_adr = d; len = l; start = 1'b1; k = cyc;
        tick();
        start = 1'b0;
    endtask

    // Returns the cycle number of the done pulse; leaves us in the following cycle.
    task automatic wait_done(input bit rnd, output int kd);
        kd = -1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done) begin kd = cyc; break; end
            @(posedge clk); #1;
            if (rnd) bus_gnt = ($urandom_range(0, 3) != 0);
        end
        if (kd < 0) chk("done_timeout", 0, 1);
        @(posedge clk); #1;
        bus_gnt = 1'b1;
    endtask

    initial begin
        int k, kd, n;
        logic [11:0] s, d, l;

        // random memory contents, loaded while reset is held
        for (int a = 0; a < 4096; a++) begin
            bd_we = 1'b1; bd_addr = 12'(a); bd_data = 8'($urandom); tick();
        end
        bd_we = 1'b0;
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_req", int'(bus_req), 0);
        chk("rst_wr", int'(mem_wr), 0);
        chk("rst_adres", int'(mem_adres), 0);
        chk("rst_dane", int'(mem_dane), 0);
        tick();
        rst = 1'b0;
        tick();

        // basic copy across pages
        bd_page(4'd5);
        bd_byte(12'h110, 8'hAA); bd_byte(12'h111, 8'hBB); bd_byte(12'h112, 8'hCC);
        launch(12'h110, 12'h220, 12'd3, k);
        wait_done(1'b0, kd);
        chk("t1_latency", kd - k, RESTORE_EN ? 16 : 14);
        chk("t1_b0", int'(mem[12'h220]), 8'hAA);
        chk("t1_b1", int'(mem[12'h221]), 8'hBB);
        chk("t1_b2", int'(mem[12'h222]), 8'hCC);
        chk("t1_page", int'(page_reg), RESTORE_EN ? 5 : 2);

        // offset 255 skipped on source
        bd_byte(12'h0FE, 8'h11); bd_byte(12'h0FF, 8'h99);
        bd_byte(12'h100, 8'h22); bd_byte(12'h101, 8'h33);
        launch(12'h0FE, 12'h300, 12'd3, k);
        wait_done(1'b0, kd);
        chk("t2_b0", int'(mem[12'h300]), 8'h11);
        chk("t2_b1", int'(mem[12'h301]), 8'h22);
        chk("t2_b2", int'(mem[12'h302]), 8'h33);

        // rejected request
        launch(12'h1FF, 12'h000, 12'd4, k);
        @(negedge clk);
        chk("t3_done", int'(done), 1);
        chk("t3_err", int'(err), 1);
        chk("t3_latency", cyc - k, 1);
        tick();

        // grant dropped for 3 cycles in the first SET_DST
        launch(12'h040, 12'h550, 12'd2, k);
        n = 0;
        for (int i = 0; i < 40 && n < 2; i++) begin
            if (mem_wr && mem_adres == 8'hFF) n++;
            if (n < 2) tick();
        end
        chk("t4_found_set_dst", n, 2);
        bus_gnt = 1'b0;
        repeat (3) tick();
        bus_gnt = 1'b1;
        wait_done(1'b0, kd);
        chk("t4_latency", kd - k, RESTORE_EN ? 15 : 13);

        // reset during the second WRITE, then a normal transfer
        launch(12'h010, 12'h700, 12'd5, k);
        n = 0;
        for (int i = 0; i < 60 && n < 2; i++) begin
            if (mem_wr && mem_adres != 8'hFF) n++;
            if (n < 2) tick();
        end
        chk("t5_found_write2", n, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_busy", int'(busy), 0);
        chk("t5_done", int'(done), 0);
        tick();
        launch(12'h010, 12'h700, 12'd5, k);
        wait_done(1'b0, kd);
        chk("t5_latency", kd - k, BASE + 20);

        // len == 0, then start pulses while busy are ignored
        launch(12'h123, 12'h456, 12'd0, k);
        @(negedge clk);
        chk("t6_done", int'(done), 1);
        chk("t6_err", int'(err), 0);
        chk("t6_latency", cyc - k, 1);
        tick();
        launch(12'h200, 12'h600, 12'd6, k);
        src_adr = 12'h1FF; dst_adr = 12'h000; len = 12'd1; start = 1'b1;
        repeat (3) tick();
        start = 1'b0;
        wait_done(1'b0, kd);
        chk("t6_latency_busy", kd - k, BASE + 24);

        // randomized transfers with random grant
        for (int t = 0; t < 40; t++) begin
            s = 12'($urandom); d = 12'($urandom); l = 12'($urandom_range(0, 24));
            if ($urandom_range(0, 9) == 0) s[7:0] = 8'hFF;
            if ($urandom_range(0, 9) == 0) d[7:0] = 8'hFF;
            if ($urandom_range(0, 4) == 0) d = s + 12'($urandom_range(1, 4));
            launch(s, d, l, k);
            bus_gnt = ($urandom_range(0, 3) != 0);
            wait_done(1'b1, kd);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
